// File: rtl/oled_cmd_sequencer.sv
// oled_cmd_sequencer: streams NUM_CMDS {D/C, byte} entries from a synchronous
// ROM into the SPI_Master byte interface. The sequencer holds chip-select low
// for the whole table and inserts GAP_CYCLES idle clocks between bytes.
// Optional build macro OLED_HW_RESET_EN: pulse the panel reset low for
// RESET_CYCLES, then wait RESET_CYCLES more, before the first byte.
module oled_cmd_sequencer #(
    parameter int NUM_CMDS     = 8,
    parameter int GAP_CYCLES   = 25,
    parameter int RESET_CYCLES = 250000,
    parameter int AW           = $clog2(NUM_CMDS)
) (
    input  logic          i_Clk,
    input  logic          i_Rst,
    input  logic          i_Start,
    output logic          o_Busy,
    output logic          o_Done,
    output logic [AW-1:0] o_Rom_Addr,
    input  logic [8:0]    i_Rom_Data,
    output logic [7:0]    o_TX_Byte,
    output logic          o_TX_DV,
    input  logic          i_TX_Ready,
    output logic          o_SPI_CS_n,
    output logic          o_OLED_DC,
    output logic          o_OLED_Res_n
);

    typedef enum logic [3:0] {
        IDLE, RST_LOW, RST_WAIT, FETCH, LOAD, SEND, SETTLE, WAIT_RDY, GAP, DONE
    } state_t;

    // The gap counter keeps at least one bit so GAP_CYCLES=0 still elaborates.
    localparam int            GW       = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
    localparam logic [AW-1:0] LAST_IDX = AW'(NUM_CMDS - 1);
    localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);

    state_t        r_state;
    state_t        w_next;
    logic [AW-1:0] r_index;
    logic [GW-1:0] r_gap_cnt;
    logic [7:0]    r_tx_byte;
    logic          r_dc;
    logic          w_idx_clr;
    logic          w_idx_inc;

`ifdef OLED_HW_RESET_EN
    localparam int            RW       = $clog2(RESET_CYCLES + 1);
    localparam logic [RW-1:0] RST_LAST = RW'(RESET_CYCLES - 1);

    logic [RW-1:0] r_rst_cnt;

    // Panel reset timer: runs through RST_LOW, restarts at 0 for RST_WAIT.
    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            r_rst_cnt <= '0;
        end else if ((r_state == RST_LOW || r_state == RST_WAIT) && r_rst_cnt != RST_LAST) begin
            r_rst_cnt <= r_rst_cnt + RW'(1);
        end else begin
            r_rst_cnt <= '0;
        end
    end

    assign o_OLED_Res_n = (r_state != RST_LOW);
`else
    // RESET_CYCLES only matters when the panel reset pulse is compiled in.
    logic w_unused_reset_cfg;
    assign w_unused_reset_cfg = (RESET_CYCLES > 0);
    assign o_OLED_Res_n       = 1'b1;
`endif

    // State register.
    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic and index control.
    always_comb begin
        w_next    = r_state;
        w_idx_clr = 1'b0;
        w_idx_inc = 1'b0;
        case (r_state)
            IDLE: begin
                if (i_Start) begin
                    w_idx_clr = 1'b1;
`ifdef OLED_HW_RESET_EN
                    w_next    = RST_LOW;
`else
                    w_next    = FETCH;
`endif
                end
            end
`ifdef OLED_HW_RESET_EN
            RST_LOW:  if (r_rst_cnt == RST_LAST) w_next = RST_WAIT;
            RST_WAIT: if (r_rst_cnt == RST_LAST) w_next = FETCH;
`endif
            FETCH:    w_next = LOAD;
            LOAD:     w_next = SEND;
            SEND:     if (i_TX_Ready) w_next = SETTLE;
            SETTLE:   w_next = WAIT_RDY;
            WAIT_RDY: begin
                if (i_TX_Ready) begin
                    if (r_index == LAST_IDX) begin
                        w_next = DONE;
                    end else if (GAP_CYCLES == 0) begin
                        w_idx_inc = 1'b1;
                        w_next    = FETCH;
                    end else begin
                        w_next = GAP;
                    end
                end
            end
            GAP: begin
                if (r_gap_cnt == GAP_LAST) begin
                    w_idx_inc = 1'b1;
                    w_next    = FETCH;
                end
            end
            DONE:     w_next = IDLE;
            default:  w_next = IDLE;
        endcase
    end

    // Datapath: table index, gap timer and the byte/DC holding registers.
    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            r_index   <= '0;
            r_gap_cnt <= '0;
            r_tx_byte <= '0;
            r_dc      <= 1'b0;
        end else begin
            if (w_idx_clr) begin
                r_index <= '0;
            end else if (w_idx_inc) begin
                r_index <= r_index + AW'(1);
            end
            if (r_state == GAP) begin
                r_gap_cnt <= r_gap_cnt + GW'(1);
            end else begin
                r_gap_cnt <= '0;
            end
            if (r_state == LOAD) begin
                r_tx_byte <= i_Rom_Data[7:0];
                r_dc      <= i_Rom_Data[8];
            end
        end
    end

    assign o_Busy     = (r_state != IDLE);
    assign o_Done     = (r_state == DONE);
    assign o_TX_DV    = (r_state == SEND) && i_TX_Ready;
    assign o_SPI_CS_n = !(r_state == FETCH || r_state == LOAD || r_state == SEND ||
                          r_state == SETTLE || r_state == WAIT_RDY || r_state == GAP);
    assign o_Rom_Addr = r_index;
    assign o_TX_Byte  = r_tx_byte;
    assign o_OLED_DC  = r_dc;

endmodule

// File: doc/oled_cmd_sequencer.md
# oled_cmd_sequencer

Parametrised command sequencer that streams a table of OLED init/control bytes from a synchronous ROM into the SPI_Master byte interface on the GoBoard. It replaces the hard-coded per-state command walk with a table-driven FSM that handles chip-select, data/command select, the SPI_Master ready/valid handshake and an inter-byte gap. An optional hardware reset pulse to the panel precedes the first byte. It sits between a top-level control FSM (start/done) and SPI_Master, with its ROM alongside.

## Interface
- NUM_CMDS, 8: entries in the command ROM; must be at least 2.
- GAP_CYCLES, 25: idle clocks between a byte completing and the next fetch; 0 means no gap.
- RESET_CYCLES, 250000: length of the panel reset low pulse, and of the recovery wait after it. Used only with OLED_HW_RESET_EN.
- AW, $clog2(NUM_CMDS): ROM address width (derived).
- i_Clk  in  1  system clock; the only clock.
- i_Rst  in  1  reset; synchronous, active-high.
- i_Start  in  1  level-sampled in IDLE only; begins a sequence.
- o_Busy  out  1  high in every state except IDLE.
- o_Done  out  1  one-cycle pulse when the sequence completes.
- o_Rom_Addr  out  AW  ROM address.
- i_Rom_Data  in  9  ROM data, valid one clock after the address: bit 8 is D/C (1 = data, 0 = command), bits [7:0] are the byte.
- o_TX_Byte  out  8  byte presented to SPI_Master.
- o_TX_DV  out  1  one-cycle valid strobe to SPI_Master.
- i_TX_Ready  in  1  SPI_Master ready.
- o_SPI_CS_n  out  1  panel chip-select, active-low.
- o_OLED_DC  out  1  panel D/C line.
- o_OLED_Res_n  out  1  panel reset, active-low.

## Operation
- States: IDLE, RST_LOW, RST_WAIT, FETCH, LOAD, SEND, SETTLE, WAIT_RDY, GAP, DONE.
- IDLE → i_Start=1 → RST_LOW when OLED_HW_RESET_EN is defined, otherwise FETCH. The index is cleared to 0 on this transition.
- RST_LOW: o_OLED_Res_n=0 for RESET_CYCLES clocks, then RST_WAIT.
- RST_WAIT: o_OLED_Res_n=1 for RESET_CYCLES clocks, then FETCH.
- FETCH: o_Rom_Addr=index; o_SPI_CS_n=0. Next state LOAD.
- LOAD: o_TX_Byte ← i_Rom_Data[7:0] and o_OLED_DC ← i_Rom_Data[8], both registered. Next state SEND.
- SEND: if i_TX_Ready=1, pulse o_TX_DV=1 for exactly one cycle and go to SETTLE. Otherwise hold in SEND with o_TX_DV=0.
- SETTLE: one cycle in which i_TX_Ready is ignored (SPI_Master drops ready the cycle after DV). Next state WAIT_RDY.
- WAIT_RDY: wait for i_TX_Ready=1.
  - If index==NUM_CMDS-1, go to DONE.
  - Else if GAP_CYCLES=0, index+1 and go to FETCH.
  - Else go to GAP.
- GAP: count GAP_CYCLES clocks, then index+1 and go to FETCH.
- o_SPI_CS_n stays low continuously from the first FETCH until DONE; it never toggles between bytes.
- DONE: o_Done=1, o_SPI_CS_n=1, for one cycle. Next state IDLE.
- Index never wraps: sequence terminates at NUM_CMDS-1.
- i_Start is ignored outside IDLE. If i_Start is held high, a new sequence begins on the cycle after DONE returns to IDLE.
- o_TX_DV is never asserted while i_TX_Ready=0, and never in two consecutive cycles.
- Counters are sized to $clog2(max+1); no overflow for the legal parameter range.

## Timing
- Reset values, applied on the first i_Clk edge with i_Rst=1 from any state including mid-transfer:
  - State IDLE, index 0.
  - o_Busy=0, o_Done=0, o_TX_DV=0, o_TX_Byte=0, o_Rom_Addr=0.
  - o_SPI_CS_n=1, o_OLED_DC=0, o_OLED_Res_n=1.
  - Counters 0.
- A byte already handed to SPI_Master before reset is not tracked. The owner of SPI_Master resets it concurrently.
- Latency, no HW reset, i_TX_Ready=1: i_Start sampled at edge k gives FETCH at k+1, LOAD at k+2, o_TX_DV high in cycle k+3.
- Per byte, with SPI_Master taking T cycles busy: 2 + 1 + 1 + T + GAP_CYCLES clocks.
- o_OLED_DC and o_TX_Byte are stable from LOAD until the next LOAD.

## Configuration
- OLED_HW_RESET_EN defined:
  - RST_LOW/RST_WAIT are active.
  - o_OLED_Res_n pulses low for RESET_CYCLES, then high for RESET_CYCLES, before the first FETCH of every sequence.
- Undefined:
  - Those states and their counter are compiled out.
  - o_OLED_Res_n is constant 1.
  - IDLE goes directly to FETCH.

## Test plan
- NUM_CMDS=4, GAP_CYCLES=3, ROM {0x0AE, 0x0A5, 0x1FF, 0x0AF}, SPI model busy 16 cycles → exactly 4 DV pulses carrying bytes AE, A5, FF, AF with DC 0, 0, 1, 0; o_SPI_CS_n low throughout; single o_Done pulse; o_Busy falls the cycle after o_Done.
- i_TX_Ready held 0 for 50 cycles in SEND → o_TX_DV stays 0, state holds; DV fires the cycle ready rises.
- GAP_CYCLES=0 → exactly 2 + 1 + 1 + 16 = 20 cycles between consecutive DV pulses.
- i_Rst asserted in WAIT_RDY on byte 2 → next cycle all outputs at reset values; fresh i_Start restarts at address 0.
- i_Start held high → second sequence's FETCH occurs two cycles after o_Done; pulsing i_Start while busy changes nothing.
- OLED_HW_RESET_EN, RESET_CYCLES=10 → o_OLED_Res_n low exactly 10 cycles, high 10 cycles, then first FETCH; without the macro, o_OLED_Res_n is constantly 1.
